// File: rtl/filter_spad_pkg.sv
// rtl/filter_spad_pkg.sv - shared states and sizing for the filter scratchpad sequencer
package filter_spad_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 6;
    localparam int DEPTH      = 2 ** DEF_ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_e;

endpackage

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - two-entry FIFO that absorbs the scratchpad read latency
module skid_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wptr_q, wptr_d;
    logic         rptr_q, rptr_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        wptr_d = wptr_q ^ push_i;
        rptr_d = rptr_q ^ pop_i;
        cnt_d  = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    // The head entry is never overwritten: a push only lands on the head slot when empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= push_data_i;
            end
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/filter_spad_seq.sv
// rtl/filter_spad_seq.sv - loads a filter into the scratchpad and replays it to the MAC
module filter_spad_seq
    import filter_spad_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [ADDR_W:0]   cfg_len_i,
    input  logic [7:0]        cfg_reps_i,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              spad_rd_o,
    output logic              spad_wr_o,
    output logic [ADDR_W-1:0] spad_addr_o,
    output logic [DATA_W-1:0] spad_wdata_o,
    input  logic [DATA_W-1:0] spad_rdata_i,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic [DATA_W-1:0] w_data_o,
    output logic              w_last_o,
    output logic              done_o
);

    localparam int              CW      = ADDR_W + 9;
    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [ADDR_W:0] len_q, len_d;
    logic [ADDR_W:0] wcnt_q, wcnt_d;
    logic [ADDR_W:0] raddr_q, raddr_d;
    logic [7:0]      reps_q, reps_d;
    logic [7:0]      pass_q, pass_d;
    logic [CW-1:0]   popcnt_q, popcnt_d;
    logic            inflight_q, inflight_d;
    logic            rtag_q, rtag_d;

    logic [CW-1:0]   total;
    logic [DATA_W:0] head;
    logic [1:0]      occ;
    logic [2:0]      budget;
    logic            pop;
    logic            rd_last;

    skid_fifo2 #(
        .W(DATA_W + 1)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_data_i ({rtag_q, spad_rdata_i}),
        .pop_i       (pop),
        .valid_o     (w_valid_o),
        .data_o      (head),
        .count_o     (occ)
    );

    assign w_last_o = head[DATA_W];
    assign w_data_o = head[DATA_W-1:0];
    assign pop      = w_valid_o & w_ready_i;
    assign total    = CW'(len_q) * CW'(reps_q);
    assign rd_last  = (raddr_q == len_q - LEN_ONE);
    // Words already buffered plus the one still coming back from the scratchpad.
    assign budget   = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        reps_d       = reps_q;
        wcnt_d       = wcnt_q;
        raddr_d      = raddr_q;
        pass_d       = pass_q;
        popcnt_d     = popcnt_q;
        inflight_d   = 1'b0;
        rtag_d       = 1'b0;
        cfg_ready_o  = 1'b0;
        load_ready_o = 1'b0;
        spad_rd_o    = 1'b0;
        spad_wr_o    = 1'b0;
        spad_addr_o  = '0;
        spad_wdata_o = '0;
        done_o       = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                S_IDLE: begin
                    cfg_ready_o = 1'b1;
                    if (cfg_valid_i) begin
                        len_d    = (cfg_len_i > LEN_MAX) ? LEN_MAX : cfg_len_i;
                        reps_d   = cfg_reps_i;
                        wcnt_d   = '0;
                        raddr_d  = '0;
                        pass_d   = '0;
                        popcnt_d = '0;
                        state_d  = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (len_q == '0 || reps_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        load_ready_o = 1'b1;
                        if (load_valid_i) begin
                            spad_wr_o    = 1'b1;
                            spad_addr_o  = wcnt_q[ADDR_W-1:0];
                            spad_wdata_o = load_data_i;
                            wcnt_d       = wcnt_q + LEN_ONE;
                            if (wcnt_q == len_q - LEN_ONE) begin
                                state_d = S_STREAM;
                            end
                        end
                    end
                end
                S_STREAM: begin
                    if (pass_q < reps_q && budget < 3'd2) begin
                        spad_rd_o   = 1'b1;
                        spad_addr_o = raddr_q[ADDR_W-1:0];
                        inflight_d  = 1'b1;
                        rtag_d      = rd_last;
                        if (rd_last) begin
                            raddr_d = '0;
                            pass_d  = pass_q + 8'd1;
                        end else begin
                            raddr_d = raddr_q + LEN_ONE;
                        end
                    end
                    if (pop) begin
                        popcnt_d = popcnt_q + CNT_ONE;
                        if (popcnt_d == total) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            reps_q     <= '0;
            wcnt_q     <= '0;
            raddr_q    <= '0;
            pass_q     <= '0;
            popcnt_q   <= '0;
            inflight_q <= 1'b0;
            rtag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            reps_q     <= reps_d;
            wcnt_q     <= wcnt_d;
            raddr_q    <= raddr_d;
            pass_q     <= pass_d;
            popcnt_q   <= popcnt_d;
            inflight_q <= inflight_d;
            rtag_q     <= rtag_d;
        end
    end

endmodule

// File: tb/tb_filter_spad_seq.sv
// tb/tb_filter_spad_seq.sv - directed self-checking bench for filter_spad_seq
module tb_filter_spad_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid, cfg_ready;
    logic [6:0] cfg_len;
    logic [7:0] cfg_reps;
    logic       load_valid, load_ready;
    logic [7:0] load_data;
    logic       spad_rd, spad_wr;
    logic [5:0] spad_addr;
    logic [7:0] spad_wdata;
    logic [7:0] spad_rdata = '0;
    logic       w_valid, w_ready, w_last, done;
    logic [7:0] w_data;

    always #5 clk = ~clk;

    filter_spad_seq dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_len_i    (cfg_len),
        .cfg_reps_i   (cfg_reps),
        .load_valid_i (load_valid),
        .load_ready_o (load_ready),
        .load_data_i  (load_data),
        .spad_rd_o    (spad_rd),
        .spad_wr_o    (spad_wr),
        .spad_addr_o  (spad_addr),
        .spad_wdata_o (spad_wdata),
        .spad_rdata_i (spad_rdata),
        .w_valid_o    (w_valid),
        .w_ready_i    (w_ready),
        .w_data_o     (w_data),
        .w_last_o     (w_last),
        .done_o       (done)
    );

    // Scratchpad: write at the edge, registered read data one cycle later.
    logic [7:0] spad_mem [64];
    always @(posedge clk) begin
        if (spad_wr) spad_mem[spad_addr] <= spad_wdata;
        if (spad_rd) spad_rdata <= spad_mem[spad_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0, nfail = 0;
    int nwr, nrd, nhs, ndone, nunstable, nover, naddr_err, nbadwr, outst;
    int nboth = 0;
    int hs_cyc, first_rd_cyc, first_v_cyc, done_cyc;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] got_data [$];
    logic       got_last [$];
    int         pop_cyc [$];
    logic [7:0] pat [64];

    always @(negedge clk) begin
        if (rst) begin
            outst      = 0;
            prev_stall = 1'b0;
        end else begin
            if (cfg_valid && cfg_ready) begin nhs++; hs_cyc = cyc; end
            if (spad_wr) begin
                if (spad_addr != nwr[5:0]) naddr_err++;
                if (!(load_valid && load_ready)) nbadwr++;
                nwr++;
            end
            if (spad_rd) begin
                if (nrd == 0) first_rd_cyc = cyc;
                nrd++;
            end
            if (spad_rd && spad_wr) nboth++;
            if (prev_stall && (!w_valid || w_data != prev_data)) nunstable++;
            if (w_valid && first_v_cyc < 0) first_v_cyc = cyc;
            if (w_valid && w_ready) begin
                got_data.push_back(w_data);
                got_last.push_back(w_last);
                pop_cyc.push_back(cyc);
            end
            outst = outst + int'(spad_rd) - int'(w_valid && w_ready);
            if (outst > 2) nover++;
            if (done) begin ndone++; done_cyc = cyc; end
            prev_stall = w_valid && !w_ready;
            prev_data  = w_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mon();
        nwr = 0; nrd = 0; nhs = 0; ndone = 0; nunstable = 0; nover = 0;
        naddr_err = 0; nbadwr = 0;
        hs_cyc = -1; first_rd_cyc = -1; first_v_cyc = -1; done_cyc = -1;
        got_data.delete(); got_last.delete(); pop_cyc.delete();
    endtask

    task automatic start_job(input int len, input int reps, input bit hold);
        clr_mon();
        cfg_len   = 7'(len);
        cfg_reps  = 8'(reps);
        cfg_valid = 1'b1;
        sample();
        step();
        if (hold) begin
            cfg_len  = 7'd7;
            cfg_reps = 8'd9;
        end else begin
            cfg_valid = 1'b0;
        end
    endtask

    task automatic load_words(input int n, input int gap);
        bit ok;
        int guard;
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = pat[i % 64];
            guard = 0;
            do begin
                sample();
                ok = load_ready;
                step();
                guard++;
            end while (!ok && guard < 50);
            load_valid = 1'b0;
            repeat (gap) step();
        end
    endtask

    task automatic wait_done(input int maxc, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            sample();
            if (ndone > 0) ok = 1'b1;
            else step();
        end
    endtask

    function automatic int data_errs(input int len, input int n);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if (got_data[i] !== pat[i % len]) e++;
        end
        return e;
    endfunction

    initial begin
        bit ok;
        int nl;
        rst = 1'b1; cfg_valid = 1'b0; cfg_len = '0; cfg_reps = '0;
        load_valid = 1'b0; load_data = '0; w_ready = 1'b0;
        clr_mon();
        repeat (3) step();
        sample();
        chk("rst_cfg_ready", cfg_ready, 0);
        step();
        rst = 1'b0;
        sample();
        chk("rst_cfg_ready_after", cfg_ready, 1);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_spad_rd", spad_rd, 0);
        chk("rst_spad_wr", spad_wr, 0);
        chk("rst_spad_addr", spad_addr, 0);
        chk("rst_spad_wdata", spad_wdata, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_w_last", w_last, 0);
        chk("rst_done", done, 0);
        step();

        // len=4 reps=3, full-rate sink
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        w_ready = 1'b1;
        start_job(4, 3, 1'b0);
        load_words(4, 0);
        wait_done(100, 1'b0, ok);
        chk("t1_done_seen", ok, 1);
        chk("t1_count", got_data.size(), 12);
        for (int i = 0; i < 12; i++) begin
            chk("t1_data", got_data[i], pat[i % 4]);
            chk("t1_last", got_last[i], (i % 4 == 3));
        end
        chk("t1_nwr", nwr, 4);
        chk("t1_first_rd", first_rd_cyc, hs_cyc + 5);
        chk("t1_first_valid", first_v_cyc, hs_cyc + 7);
        chk("t1_no_gaps", pop_cyc[11] - pop_cyc[0], 11);
        chk("t1_done_lat", done_cyc, pop_cyc[11] + 1);
        chk("t1_cfg_ready_in_done", cfg_ready, 0);
        step();
        sample();
        chk("t1_cfg_ready_back", cfg_ready, 1);
        chk("t1_ndone", ndone, 1);
        step();

        // len=64 reps=2, random sink
        for (int i = 0; i < 64; i++) pat[i] = 8'((i * 37 + 5) & 255);
        start_job(64, 2, 1'b0);
        load_words(64, 0);
        wait_done(2000, 1'b1, ok);
        chk("t2_done_seen", ok, 1);
        chk("t2_count", got_data.size(), 128);
        chk("t2_data_errs", data_errs(64, 128), 0);
        nl = 0;
        foreach (got_last[i]) if (got_last[i]) nl++;
        chk("t2_lasts", nl, 2);
        chk("t2_last_pos", {got_last[63], got_last[127]}, 2'b11);
        chk("t2_unstable", nunstable, 0);
        chk("t2_overbuffer", nover, 0);
        chk("t2_nrd", nrd, 128);
        w_ready = 1'b1;
        step();

        // zero length, then zero reps
        start_job(0, 3, 1'b0);
        wait_done(20, 1'b0, ok);
        chk("t3_len0_done_lat", done_cyc, hs_cyc + 2);
        chk("t3_len0_wr_rd", nwr + nrd, 0);
        step();
        start_job(5, 0, 1'b0);
        wait_done(20, 1'b0, ok);
        chk("t3_reps0_done_lat", done_cyc, hs_cyc + 2);
        chk("t3_reps0_wr_rd", nwr + nrd, 0);
        step();

        // oversize length clamps to 64
        for (int i = 0; i < 64; i++) pat[i] = 8'((255 - i * 3) & 255);
        start_job(100, 1, 1'b0);
        load_words(64, 0);
        wait_done(500, 1'b0, ok);
        chk("t4_done_seen", ok, 1);
        chk("t4_nwr", nwr, 64);
        chk("t4_addr_errs", naddr_err, 0);
        chk("t4_count", got_data.size(), 64);
        chk("t4_data_errs", data_errs(64, 64), 0);
        step();

        // reset mid-stream with the buffer full
        pat[0] = 8'h5A; pat[1] = 8'h6B; pat[2] = 8'h7C; pat[3] = 8'h8D;
        start_job(4, 2, 1'b0);
        w_ready = 1'b0;
        load_words(4, 0);
        repeat (4) step();
        sample();
        chk("t5_full_valid", w_valid, 1);
        chk("t5_full_outst", outst, 2);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        chk("t5_w_valid", w_valid, 0);
        chk("t5_w_data", w_data, 0);
        chk("t5_idle", cfg_ready, 1);
        chk("t5_spad_rd", spad_rd, 0);
        step();
        pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3;
        w_ready = 1'b1;
        start_job(3, 2, 1'b0);
        load_words(3, 0);
        wait_done(100, 1'b0, ok);
        chk("t5_new_done", ok, 1);
        chk("t5_new_count", got_data.size(), 6);
        chk("t5_new_data_errs", data_errs(3, 6), 0);
        step();

        // load gaps with cfg_valid held through the job
        for (int i = 0; i < 5; i++) pat[i] = 8'(8'h50 + i);
        start_job(5, 2, 1'b1);
        load_words(5, 1);
        wait_done(200, 1'b0, ok);
        cfg_valid = 1'b0;
        chk("t6_done_seen", ok, 1);
        chk("t6_nwr", nwr, 5);
        chk("t6_bad_wr", nbadwr, 0);
        chk("t6_handshakes", nhs, 1);
        chk("t6_count", got_data.size(), 10);
        chk("t6_data_errs", data_errs(5, 10), 0);
        chk("t6_ndone", ndone, 1);
        step();
        step();
        chk("rd_wr_together", nboth, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
